// File: rtl/battle_pkg.sv
// battle_pkg: shared types and constants for the battle turn sequencer.
//   - state_e     : turn FSM states
//   - MoveDmg*/MoveAcc* : move-table damage and accuracy per move code
//   - Side*/Win*  : attacker and winner encodings
//   - HpW/DmgW    : HP and damage field widths
package battle_pkg;

    localparam int unsigned HpW   = 8;
    localparam int unsigned DmgW  = 4;
    localparam int unsigned RollW = 4;

    typedef enum logic [2:0] {
        StCollect = 3'd0,
        StRoll1   = 3'd1,
        StApply1  = 3'd2,
        StRoll2   = 3'd3,
        StApply2  = 3'd4,
        StOver    = 3'd5
    } state_e;

    // Move table: damage / accuracy (hit when roll <= accuracy).
    localparam logic [DmgW-1:0]  MoveDmg0 = 4'd1;
    localparam logic [DmgW-1:0]  MoveDmg1 = 4'd3;
    localparam logic [DmgW-1:0]  MoveDmg2 = 4'd5;
    localparam logic [DmgW-1:0]  MoveDmg3 = 4'd9;
    localparam logic [RollW-1:0] MoveAcc0 = 4'd15;
    localparam logic [RollW-1:0] MoveAcc1 = 4'd12;
    localparam logic [RollW-1:0] MoveAcc2 = 4'd10;
    localparam logic [RollW-1:0] MoveAcc3 = 4'd5;

    localparam logic       SideP1  = 1'b0;
    localparam logic       SideP2  = 1'b1;
    localparam logic [1:0] WinNone = 2'b00;
    localparam logic [1:0] WinP1   = 2'b01;
    localparam logic [1:0] WinP2   = 2'b10;

endpackage

// File: rtl/battle_lfsr.sv
// battle_lfsr: 16-bit Galois LFSR (taps 16,14,13,11), advances every cycle.
//   clk    : system clock
//   resetn : synchronous active-low reset, loads SEED
//   rnd    : low bits of the LFSR state used as the random roll
module battle_lfsr
    import battle_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             resetn,
    output logic [RollW-1:0] rnd
);

    logic [15:0] lfsr_q, lfsr_d;

    // Right-shifting Galois form; mask 0xB400 realises taps 16,14,13,11.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign rnd = lfsr_q[RollW-1:0];

endmodule

// File: rtl/move_mux.sv
// move_mux: combinational move-table lookup.
//   move : 2-bit move code
//   dmg  : damage for that move
//   accu : accuracy threshold for that move
module move_mux
    import battle_pkg::*;
(
    input  logic [1:0]       move,
    output logic [DmgW-1:0]  dmg,
    output logic [RollW-1:0] accu
);

    always_comb begin
        dmg  = MoveDmg0;
        accu = MoveAcc0;
        unique case (move)
            2'b00: begin dmg = MoveDmg0; accu = MoveAcc0; end
            2'b01: begin dmg = MoveDmg1; accu = MoveAcc1; end
            2'b10: begin dmg = MoveDmg2; accu = MoveAcc2; end
            2'b11: begin dmg = MoveDmg3; accu = MoveAcc3; end
            default: begin dmg = MoveDmg0; accu = MoveAcc0; end
        endcase
    end

endmodule

// File: rtl/battle_turn_ctrl.sv
// battle_turn_ctrl: collects one move per player per round, resolves two attacks
// (first attacker alternates each round), applies saturating damage and stops the
// game when a player's HP reaches 0.
//   Inputs : clk, resetn (sync, active-low), p1/p2_move + p1/p2_valid, new_game,
//            roll_force_en/roll_force (test hook overriding the LFSR roll)
//   Outputs: p1/p2_hp, p1/p2_pending, hit_valid pulse with hit/attacker/dmg_dealt,
//            round counter, game_over, winner
module battle_turn_ctrl
    import battle_pkg::*;
#(
    parameter logic [HpW-1:0] START_HP  = 8'd30,
    parameter logic [15:0]    LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [1:0]       p1_move,
    input  logic [1:0]       p2_move,
    input  logic             p1_valid,
    input  logic             p2_valid,
    input  logic             new_game,
    input  logic             roll_force_en,
    input  logic [RollW-1:0] roll_force,
    output logic [HpW-1:0]   p1_hp,
    output logic [HpW-1:0]   p2_hp,
    output logic             p1_pending,
    output logic             p2_pending,
    output logic             hit_valid,
    output logic             hit,
    output logic             attacker,
    output logic [DmgW-1:0]  dmg_dealt,
    output logic [7:0]       round,
    output logic             game_over,
    output logic [1:0]       winner
);

    state_e           state_q, state_d;
    logic [HpW-1:0]   p1_hp_q, p1_hp_d, p2_hp_q, p2_hp_d;
    logic [1:0]       p1_mv_q, p1_mv_d, p2_mv_q, p2_mv_d;
    logic             p1_pend_q, p1_pend_d, p2_pend_q, p2_pend_d;
    logic             first_q, first_d;
    logic [RollW-1:0] roll_q, roll_d;
    logic             hit_valid_q, hit_valid_d;
    logic             hit_q, hit_d;
    logic             attacker_q, attacker_d;
    logic [DmgW-1:0]  dmg_q, dmg_d;
    logic [7:0]       round_q, round_d;
    logic             game_over_q, game_over_d;
    logic [1:0]       winner_q, winner_d;

    logic [RollW-1:0] lfsr_rnd;
    logic [DmgW-1:0]  p1_dmg, p2_dmg;
    logic [RollW-1:0] p1_acc, p2_acc;

    battle_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .resetn (resetn),
        .rnd    (lfsr_rnd)
    );

    move_mux u_p1_mux (
        .move (p1_mv_q),
        .dmg  (p1_dmg),
        .accu (p1_acc)
    );

    move_mux u_p2_mux (
        .move (p2_mv_q),
        .dmg  (p2_dmg),
        .accu (p2_acc)
    );

    logic             second_half;
    logic             cur_att;
    logic [DmgW-1:0]  att_dmg;
    logic [RollW-1:0] att_acc;
    logic [HpW-1:0]   def_hp;
    logic [HpW-1:0]   dmg_ext;
    logic             hit_now;
    logic             faint;
    logic [HpW-1:0]   def_hp_new;
    logic [DmgW-1:0]  dealt;

    // Attack datapath, shared by both ROLL/APPLY halves of the round.
    always_comb begin
        second_half = (state_q == StRoll2) || (state_q == StApply2);
        cur_att     = second_half ? ~first_q : first_q;
        att_dmg     = (cur_att == SideP2) ? p2_dmg : p1_dmg;
        att_acc     = (cur_att == SideP2) ? p2_acc : p1_acc;
        def_hp      = (cur_att == SideP2) ? p1_hp_q : p2_hp_q;
        dmg_ext     = {{(HpW-DmgW){1'b0}}, att_dmg};
        hit_now     = (roll_q <= att_acc);
        faint       = hit_now && (dmg_ext >= def_hp);
        if (!hit_now) begin
            def_hp_new = def_hp;
            dealt      = '0;
        end else if (faint) begin
            // Defender HP is at most dmg here, so it fits in the damage field.
            def_hp_new = '0;
            dealt      = def_hp[DmgW-1:0];
        end else begin
            def_hp_new = def_hp - dmg_ext;
            dealt      = att_dmg;
        end
    end

    always_comb begin
        state_d     = state_q;
        p1_hp_d     = p1_hp_q;
        p2_hp_d     = p2_hp_q;
        p1_mv_d     = p1_mv_q;
        p2_mv_d     = p2_mv_q;
        p1_pend_d   = p1_pend_q;
        p2_pend_d   = p2_pend_q;
        first_d     = first_q;
        roll_d      = roll_q;
        hit_valid_d = 1'b0;
        hit_d       = hit_q;
        attacker_d  = attacker_q;
        dmg_d       = dmg_q;
        round_d     = round_q;
        game_over_d = game_over_q;
        winner_d    = winner_q;

        if (new_game) begin
            state_d     = StCollect;
            p1_hp_d     = START_HP;
            p2_hp_d     = START_HP;
            p1_pend_d   = 1'b0;
            p2_pend_d   = 1'b0;
            first_d     = SideP1;
            round_d     = '0;
            game_over_d = 1'b0;
            winner_d    = WinNone;
        end else begin
            unique case (state_q)
                StCollect: begin
                    if (p1_valid) begin
                        p1_mv_d   = p1_move;
                        p1_pend_d = 1'b1;
                    end
                    if (p2_valid) begin
                        p2_mv_d   = p2_move;
                        p2_pend_d = 1'b1;
                    end
                    if ((p1_pend_q || p1_valid) && (p2_pend_q || p2_valid)) begin
                        state_d = StRoll1;
                    end
                end
                StRoll1, StRoll2: begin
                    roll_d  = roll_force_en ? roll_force : lfsr_rnd;
                    state_d = (state_q == StRoll1) ? StApply1 : StApply2;
                end
                StApply1, StApply2: begin
                    hit_valid_d = 1'b1;
                    hit_d       = hit_now;
                    attacker_d  = cur_att;
                    dmg_d       = dealt;
                    if (cur_att == SideP2) begin
                        p1_hp_d = def_hp_new;
                    end else begin
                        p2_hp_d = def_hp_new;
                    end
                    if (faint) begin
                        // Remaining attack is skipped; round is not counted.
                        state_d     = StOver;
                        game_over_d = 1'b1;
                        winner_d    = (cur_att == SideP2) ? WinP2 : WinP1;
                    end else if (state_q == StApply1) begin
                        state_d = StRoll2;
                    end else begin
                        state_d   = StCollect;
                        round_d   = (round_q == 8'hFF) ? round_q : round_q + 8'd1;
                        p1_pend_d = 1'b0;
                        p2_pend_d = 1'b0;
                        first_d   = ~first_q;
                    end
                end
                StOver: begin
                    state_d = StOver;
                end
                default: begin
                    state_d = StCollect;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= StCollect;
            p1_hp_q     <= START_HP;
            p2_hp_q     <= START_HP;
            p1_mv_q     <= 2'b00;
            p2_mv_q     <= 2'b00;
            p1_pend_q   <= 1'b0;
            p2_pend_q   <= 1'b0;
            first_q     <= SideP1;
            roll_q      <= '0;
            hit_valid_q <= 1'b0;
            hit_q       <= 1'b0;
            attacker_q  <= SideP1;
            dmg_q       <= '0;
            round_q     <= '0;
            game_over_q <= 1'b0;
            winner_q    <= WinNone;
        end else begin
            state_q     <= state_d;
            p1_hp_q     <= p1_hp_d;
            p2_hp_q     <= p2_hp_d;
            p1_mv_q     <= p1_mv_d;
            p2_mv_q     <= p2_mv_d;
            p1_pend_q   <= p1_pend_d;
            p2_pend_q   <= p2_pend_d;
            first_q     <= first_d;
            roll_q      <= roll_d;
            hit_valid_q <= hit_valid_d;
            hit_q       <= hit_d;
            attacker_q  <= attacker_d;
            dmg_q       <= dmg_d;
            round_q     <= round_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
        end
    end

    assign p1_hp      = p1_hp_q;
    assign p2_hp      = p2_hp_q;
    assign p1_pending = p1_pend_q;
    assign p2_pending = p2_pend_q;
    assign hit_valid  = hit_valid_q;
    assign hit        = hit_q;
    assign attacker   = attacker_q;
    assign dmg_dealt  = dmg_q;
    assign round      = round_q;
    assign game_over  = game_over_q;
    assign winner     = winner_q;

endmodule
